uart_word_tx: RTL and testbench

// - Downstream transmit stage of the core: serialises each 16-bit result word onto a UART line.
// - Frame format is 8N1, or 8N2 when STOP_BITS = 2.
// - Each word goes out as two bytes, low byte first.
// - Returns tx_done to the core as the "word sent, give me the next" handshake.

---
 rtl/core_pkg.sv | 19 +
 rtl/uart_word_tx_if.sv | 32 +++
 rtl/uart_word_tx_baud_tick_gen.sv | 37 +++
 rtl/uart_word_tx.sv | 125 ++++++++++++
 tb/tb_uart_word_tx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and widths for the word-serialising UART transmit stage.
//   uart_tx_state_t : transmitter FSM state encoding
//   WORD_W / BYTE_W : result word width and UART byte width
// ---------------------------------------------------------------------------
package core_pkg;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

endpackage : core_pkg

// File: rtl/uart_word_tx_if.sv
// ---------------------------------------------------------------------------
// uart_word_tx_if
// Handshake and line signals between the core and the UART word transmitter.
//   data_in    : word to transmit (core -> tx)
//   data_valid : send request (core -> tx)
//   tx_ready   : transmitter idle, can accept a word (tx -> core)
//   tx_done    : one-cycle "word sent" pulse (tx -> core)
//   tx_busy    : frame on the line, always ~tx_ready (tx -> core)
//   txd        : UART serial line, idles high (tx -> pin)
// Modports: master = core side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_word_tx_if;
   import core_pkg::*;

   logic [WORD_W-1:0] data_in;
   logic              data_valid;
   logic              tx_ready;
   logic              tx_done;
   logic              tx_busy;
   logic              txd;

   modport master (
      output data_in, data_valid,
      input  tx_ready, tx_done, tx_busy, txd
   );

   modport slave (
      input  data_in, data_valid,
      output tx_ready, tx_done, tx_busy, txd
   );

endinterface : uart_word_tx_if

// File: rtl/uart_word_tx_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and wraps.
//   clk   : system clock
//   rstb  : asynchronous active-low reset
//   clear : forces the counter to 0 (held while the transmitter is idle)
//   en    : advance the counter
//   tick  : high on the last cycle of each bit period
// ---------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rstb,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == LAST_CNT);

endmodule : baud_tick_gen

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
// Serialises 16-bit words onto a UART line as two 8N1 (or 8N2) bytes,
// low byte first, and pulses tx_done when the word's last stop bit ends.
//   clk  : system clock, all state on posedge
//   rstb : asynchronous active-low reset; truncates any frame in flight
//   bus  : uart_word_tx_if.slave (data_in, data_valid, tx_ready, tx_done,
//          tx_busy, txd)
// Parameters: CLKS_PER_BIT (>= 2), STOP_BITS (1 or 2).
// ---------------------------------------------------------------------------
module uart_word_tx
   import core_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            rstb,
   uart_word_tx_if.slave   bus
);

   localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic [2:0] LAST_BIT = 3'(BYTE_W - 1);

   uart_tx_state_t    state_q;
   logic [WORD_W-1:0] shift_q;
   logic [2:0]        bit_idx_q;
   logic              byte_idx_q;
   logic              stop_idx_q;
   logic              txd_q;
   logic              tx_ready_q;
   logic              tx_busy_q;
   logic              tx_done_q;
   logic              tick;
   logic              baud_clear;

   // Counter sits at 0 while idle, so the first bit period starts
   // exactly on the cycle after the accept.
   assign baud_clear = (state_q == TX_IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rstb  (rstb),
      .clear (baud_clear),
      .en    (~baud_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= TX_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= 1'b0;
         stop_idx_q <= 1'b0;
         txd_q      <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         unique case (state_q)
            TX_IDLE: begin
               if (bus.data_valid) begin
                  shift_q    <= bus.data_in;
                  byte_idx_q <= 1'b0;
                  txd_q      <= 1'b0;
                  tx_ready_q <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  state_q    <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  bit_idx_q <= '0;
                  txd_q     <= shift_q[0];
                  state_q   <= TX_DATA;
               end
            end
            TX_DATA: begin
               // Shifting on every data bit leaves the high byte in
               // shift_q[7:0] once the low byte has gone out.
               if (tick) begin
                  shift_q <= {1'b0, shift_q[WORD_W-1:1]};
                  if (bit_idx_q == LAST_BIT) begin
                     stop_idx_q <= 1'b0;
                     txd_q      <= 1'b1;
                     state_q    <= TX_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     txd_q     <= shift_q[1];
                  end
               end
            end
            TX_STOP: begin
               if (tick) begin
                  if (stop_idx_q != LAST_STOP) begin
                     stop_idx_q <= 1'b1;
                  end else if (!byte_idx_q) begin
                     byte_idx_q <= 1'b1;
                     txd_q      <= 1'b0;
                     state_q    <= TX_START;
                  end else begin
                     // Done and ready rise together so the core can
                     // hand over the next word in this very cycle.
                     tx_done_q  <= 1'b1;
                     tx_ready_q <= 1'b1;
                     tx_busy_q  <= 1'b0;
                     state_q    <= TX_IDLE;
                  end
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign bus.txd      = txd_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.tx_busy  = tx_busy_q;
   assign bus.tx_done  = tx_done_q;

endmodule : uart_word_tx

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
// Directed bench for uart_word_tx. dut1 uses CLKS_PER_BIT=4, STOP_BITS=1;
// dut2 uses CLKS_PER_BIT=4, STOP_BITS=2. txd and flags are captured once
// per cycle, 1 time unit after the clock edge, starting at the accept edge.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;
   import core_pkg::*;

   localparam int CPB = 4;

   logic clk  = 1'b0;
   logic rstb = 1'b0;

   always #5 clk = ~clk;

   uart_word_tx_if bus1 ();
   uart_word_tx_if bus2 ();

   uart_word_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus1.slave)
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus2.slave)
   );

   int checks   = 0;
   int failures = 0;

   logic line1 [0:199];
   logic done1 [0:199];
   logic rdy1  [0:199];
   logic busy1 [0:199];
   logic line2 [0:199];
   logic done2 [0:199];

   // Sample n cycles; sample k is taken 1 unit after the k-th edge
   // following the call (k=0 at the current edge). Optionally raises
   // data_valid on bus1 for one edge after sample inj_k.
   task automatic record(input int n, input int inj_k, input logic [15:0] inj_w);
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         line1[k] = bus1.txd;
         done1[k] = bus1.tx_done;
         rdy1[k]  = bus1.tx_ready;
         busy1[k] = bus1.tx_busy;
         line2[k] = bus2.txd;
         done2[k] = bus2.tx_done;
         bus1.data_valid = 1'b0;
         bus2.data_valid = 1'b0;
         if (k == inj_k) begin
            bus1.data_in    = inj_w;
            bus1.data_valid = 1'b1;
         end
      end
   endtask

   // Present a word and return at the accepting posedge.
   task automatic start_word(input int which, input logic [15:0] w);
      @(negedge clk);
      checks++;
      if (which == 1) begin
         if (bus1.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ready1 got=%b want=1", bus1.tx_ready);
         end
         bus1.data_in    = w;
         bus1.data_valid = 1'b1;
      end else begin
         if (bus2.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ready2 got=%b want=1", bus2.tx_ready);
         end
         bus2.data_in    = w;
         bus2.data_valid = 1'b1;
      end
      @(posedge clk);
   endtask

   // Receiver model: sample each data bit in the middle of its bit time.
   function automatic logic [7:0] rx_byte(input int which, input int base);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b[i] = (which == 1) ? line1[base + CPB*(1+i) + 2] : line2[base + CPB*(1+i) + 2];
      end
      return b;
   endfunction

   task automatic test_reset();
      bus1.data_valid = 1'b0; bus1.data_in = '0;
      bus2.data_valid = 1'b0; bus2.data_in = '0;
      rstb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 8;
      if (bus1.txd !== 1'b1)      begin failures++; $display("FAIL reset_txd1 got=%b want=1", bus1.txd); end
      if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b want=1", bus1.tx_ready); end
      if (bus1.tx_done !== 1'b0)  begin failures++; $display("FAIL reset_done1 got=%b want=0", bus1.tx_done); end
      if (bus1.tx_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy1 got=%b want=0", bus1.tx_busy); end
      if (bus2.txd !== 1'b1)      begin failures++; $display("FAIL reset_txd2 got=%b want=1", bus2.txd); end
      if (bus2.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready2 got=%b want=1", bus2.tx_ready); end
      if (bus2.tx_done !== 1'b0)  begin failures++; $display("FAIL reset_done2 got=%b want=0", bus2.tx_done); end
      if (bus2.tx_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy2 got=%b want=0", bus2.tx_busy); end
      @(negedge clk);
      rstb = 1'b1;
      $display("reset: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_word_a55a();
      logic exp_bits [20];
      exp_bits = '{1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,
                   1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1};
      start_word(1, 16'hA55A);
      record(81, -1, 16'h0);
      for (int k = 0; k < 80; k++) begin
         checks++;
         if (line1[k] !== exp_bits[k/CPB]) begin
            failures++;
            $display("FAIL a55a_txd cycle=%0d got=%b want=%b", k, line1[k], exp_bits[k/CPB]);
         end
         checks++;
         if (done1[k] !== 1'b0) begin
            failures++;
            $display("FAIL a55a_early_done cycle=%0d got=%b want=0", k, done1[k]);
         end
      end
      checks += 5;
      if (done1[80] !== 1'b1) begin failures++; $display("FAIL a55a_done80 got=%b want=1", done1[80]); end
      if (rdy1[80] !== 1'b1)  begin failures++; $display("FAIL a55a_ready80 got=%b want=1", rdy1[80]); end
      if (line1[80] !== 1'b1) begin failures++; $display("FAIL a55a_idle80 got=%b want=1", line1[80]); end
      if (rdy1[0] !== 1'b0)   begin failures++; $display("FAIL a55a_ready_drop got=%b want=0", rdy1[0]); end
      if (busy1[40] !== 1'b1) begin failures++; $display("FAIL a55a_busy40 got=%b want=1", busy1[40]); end
      $display("word 0xA55A: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_back_to_back();
      int n_done;
      start_word(1, 16'h1357);
      record(81, -1, 16'h0);
      checks++;
      if (done1[80] !== 1'b1 || rdy1[80] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first_done got=%b/%b want=1/1", done1[80], rdy1[80]);
      end
      // Still inside the tx_done cycle: hand over the next word now.
      bus1.data_in    = 16'h00FF;
      bus1.data_valid = 1'b1;
      @(posedge clk);
      record(81, -1, 16'h0);
      n_done = 0;
      for (int k = 0; k <= 80; k++) if (done1[k] === 1'b1) n_done++;
      checks += 5;
      if (line1[0] !== 1'b0) begin failures++; $display("FAIL b2b_start_bit got=%b want=0", line1[0]); end
      if (rx_byte(1, 0) !== 8'hFF)  begin failures++; $display("FAIL b2b_byte0 got=%h want=ff", rx_byte(1, 0)); end
      if (rx_byte(1, 40) !== 8'h00) begin failures++; $display("FAIL b2b_byte1 got=%h want=00", rx_byte(1, 40)); end
      if (done1[80] !== 1'b1) begin failures++; $display("FAIL b2b_done80 got=%b want=1", done1[80]); end
      if (n_done != 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", n_done); end
      $display("back-to-back 0x00FF: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_busy_drop();
      int n_done;
      int n_low;
      start_word(1, 16'hBEEF);
      record(161, 30, 16'h1234);
      n_done = 0;
      n_low  = 0;
      for (int k = 0; k <= 160; k++) if (done1[k] === 1'b1) n_done++;
      for (int k = 81; k <= 160; k++) if (line1[k] !== 1'b1) n_low++;
      checks += 5;
      if (rx_byte(1, 0) !== 8'hEF)  begin failures++; $display("FAIL busy_byte0 got=%h want=ef", rx_byte(1, 0)); end
      if (rx_byte(1, 40) !== 8'hBE) begin failures++; $display("FAIL busy_byte1 got=%h want=be", rx_byte(1, 40)); end
      if (n_done != 1) begin failures++; $display("FAIL busy_done_count got=%0d want=1", n_done); end
      if (done1[80] !== 1'b1) begin failures++; $display("FAIL busy_done80 got=%b want=1", done1[80]); end
      if (n_low != 0) begin failures++; $display("FAIL busy_extra_frame low_cycles=%0d want=0", n_low); end
      $display("busy drop 0xBEEF/0x1234: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_midframe_reset();
      int n_done;
      start_word(1, 16'h5AC3);
      record(55, -1, 16'h0);
      checks++;
      if (line1[54] !== 1'b0) begin failures++; $display("FAIL mrst_pre_txd got=%b want=0", line1[54]); end
      rstb = 1'b0;
      #1;
      checks += 4;
      if (bus1.txd !== 1'b1)      begin failures++; $display("FAIL mrst_txd got=%b want=1", bus1.txd); end
      if (bus1.tx_ready !== 1'b1) begin failures++; $display("FAIL mrst_ready got=%b want=1", bus1.tx_ready); end
      if (bus1.tx_busy !== 1'b0)  begin failures++; $display("FAIL mrst_busy got=%b want=0", bus1.tx_busy); end
      if (bus1.tx_done !== 1'b0)  begin failures++; $display("FAIL mrst_done got=%b want=0", bus1.tx_done); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstb = 1'b1;
      start_word(1, 16'h0001);
      record(81, -1, 16'h0);
      n_done = 0;
      for (int k = 0; k <= 80; k++) if (done1[k] === 1'b1) n_done++;
      checks += 4;
      if (rx_byte(1, 0) !== 8'h01)  begin failures++; $display("FAIL mrst_byte0 got=%h want=01", rx_byte(1, 0)); end
      if (rx_byte(1, 40) !== 8'h00) begin failures++; $display("FAIL mrst_byte1 got=%h want=00", rx_byte(1, 40)); end
      if (done1[80] !== 1'b1) begin failures++; $display("FAIL mrst_done80 got=%b want=1", done1[80]); end
      if (n_done != 1) begin failures++; $display("FAIL mrst_done_count got=%0d want=1", n_done); end
      $display("mid-frame reset then 0x0001: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_two_stop();
      int n_low;
      start_word(2, 16'hFFFF);
      record(89, -1, 16'h0);
      n_low = 0;
      for (int k = 36; k <= 43; k++) if (line2[k] !== 1'b1) n_low++;
      for (int k = 80; k <= 87; k++) if (line2[k] !== 1'b1) n_low++;
      checks += 7;
      if (line2[2] !== 1'b0)  begin failures++; $display("FAIL stop2_start0 got=%b want=0", line2[2]); end
      if (n_low != 0) begin failures++; $display("FAIL stop2_stop_bits low_cycles=%0d want=0", n_low); end
      if (line2[44] !== 1'b0) begin failures++; $display("FAIL stop2_start1 got=%b want=0", line2[44]); end
      if (rx_byte(2, 0) !== 8'hFF)  begin failures++; $display("FAIL stop2_byte0 got=%h want=ff", rx_byte(2, 0)); end
      if (rx_byte(2, 44) !== 8'hFF) begin failures++; $display("FAIL stop2_byte1 got=%h want=ff", rx_byte(2, 44)); end
      if (done2[87] !== 1'b0) begin failures++; $display("FAIL stop2_done87 got=%b want=0", done2[87]); end
      if (done2[88] !== 1'b1) begin failures++; $display("FAIL stop2_done88 got=%b want=1", done2[88]); end
      $display("two stop bits 0xFFFF: checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      test_reset();
      test_word_a55a();
      test_back_to_back();
      test_busy_drop();
      test_midframe_reset();
      test_two_stop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_word_tx
